agu_lsq_unit: RTL and testbench

- Parametrised load/store execution unit for the Tomasulo backend. Successor to the single-cycle combinational AGU.
- Computes the effective address (base + imm) and buffers issued memory ops in an in-order queue of depth DEPTH.
- Drives a data-memory request/grant/rvalid handshake with variable latency.
- Broadcasts results to the CDB with tag, under a valid/ready handshake. Supports byte/half/word access with byte enables, sign/zero extension, and misalignment flagging.

---
 rtl/agu_lsq_unit_if.sv | 55 +++++
 rtl/agu_lsq_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_agu_lsq_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/agu_lsq_unit_if.sv
// rtl/agu_lsq_unit_if.sv - issue, data-memory and CDB signal bundle for the load/store unit
interface agu_lsq_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    // issue side (reservation station -> unit)
    logic                issue_valid;
    logic                issue_ready;
    logic [XLEN-1:0]     issue_base;
    logic [XLEN-1:0]     issue_imm;
    logic [XLEN-1:0]     issue_data;
    logic                issue_store;
    logic [1:0]          issue_size;
    logic                issue_unsigned;
    logic [TAG_W-1:0]    issue_tag;

    // data-memory request/grant/rvalid
    logic                mem_req;
    logic                mem_gnt;
    logic                mem_we;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_rvalid;
    logic [XLEN-1:0]     mem_rdata;

    // common data bus broadcast
    logic                cdb_valid;
    logic                cdb_ready;
    logic [XLEN-1:0]     cdb_data;
    logic [TAG_W-1:0]    cdb_tag;
    logic                cdb_exc;

    // the load/store unit itself
    modport master (
        input  issue_valid, issue_base, issue_imm, issue_data, issue_store,
        input  issue_size, issue_unsigned, issue_tag,
        output issue_ready,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output cdb_valid, cdb_data, cdb_tag, cdb_exc,
        input  cdb_ready
    );

    // the surrounding pipeline and memory
    modport slave (
        output issue_valid, issue_base, issue_imm, issue_data, issue_store,
        output issue_size, issue_unsigned, issue_tag,
        input  issue_ready,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  cdb_valid, cdb_data, cdb_tag, cdb_exc,
        output cdb_ready
    );
endinterface

// File: rtl/agu_lsq_unit.sv
// rtl/agu_lsq_unit.sv - address generation plus in-order load/store queue with memory and CDB handshakes
module agu_lsq_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    agu_lsq_unit_if.master   bus
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // queue storage, one field per array
    logic [XLEN-1:0]  r_q_ea    [DEPTH];
    logic [XLEN-1:0]  r_q_data  [DEPTH];
    logic             r_q_store [DEPTH];
    logic [1:0]       r_q_size  [DEPTH];
    logic             r_q_uns   [DEPTH];
    logic [TAG_W-1:0] r_q_tag   [DEPTH];
    logic             r_q_mis   [DEPTH];

    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_discard;
    logic [XLEN-1:0]  r_cdb_data;
    logic [TAG_W-1:0] r_cdb_tag;
    logic             r_cdb_exc;

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_pop;
    logic [XLEN-1:0]  w_ea;
    logic [1:0]       w_size;
    logic             w_mis;

    logic [PW-1:0]    w_hidx;
    logic [XLEN-1:0]  w_h_ea;
    logic [XLEN-1:0]  w_h_data;
    logic             w_h_store;
    logic [1:0]       w_h_size;
    logic             w_h_uns;
    logic [TAG_W-1:0] w_h_tag;
    logic             w_h_mis;
    logic [OFFW-1:0]  w_off;

    logic [NB-1:0]    w_be;
    logic [XLEN-1:0]  w_wdata;
    logic [XLEN-1:0]  w_shift;
    logic [XLEN-1:0]  w_ld;

    logic             w_mem_req;
    logic             w_cap;
    logic [XLEN-1:0]  w_cap_data;
    logic             w_cap_exc;
    logic             w_disc_set;

    // full/empty from the extra pointer MSB; issue_ready only reflects registered occupancy
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_enq   = bus.issue_valid && !w_full && !flush;
    assign bus.issue_ready = !w_full;

    // effective address and alignment are resolved once, at enqueue time
    assign w_ea   = bus.issue_base + bus.issue_imm;
    assign w_size = (bus.issue_size == 2'd3) ? 2'd2 : bus.issue_size;
    assign w_mis  = ((w_size == 2'd1) && w_ea[0]) ||
                    ((w_size == 2'd2) && (w_ea[OFFW-1:0] != '0));

    // queue payload write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_ea[r_wptr[PW-1:0]]    <= w_ea;
            r_q_data[r_wptr[PW-1:0]]  <= bus.issue_data;
            r_q_store[r_wptr[PW-1:0]] <= bus.issue_store;
            r_q_size[r_wptr[PW-1:0]]  <= w_size;
            r_q_uns[r_wptr[PW-1:0]]   <= bus.issue_unsigned;
            r_q_tag[r_wptr[PW-1:0]]   <= bus.issue_tag;
            r_q_mis[r_wptr[PW-1:0]]   <= w_mis;
        end
    end

    // head-of-queue view
    assign w_hidx    = r_rptr[PW-1:0];
    assign w_h_ea    = r_q_ea[w_hidx];
    assign w_h_data  = r_q_data[w_hidx];
    assign w_h_store = r_q_store[w_hidx];
    assign w_h_size  = r_q_size[w_hidx];
    assign w_h_uns   = r_q_uns[w_hidx];
    assign w_h_tag   = r_q_tag[w_hidx];
    assign w_h_mis   = r_q_mis[w_hidx];
    assign w_off     = w_h_ea[OFFW-1:0];

    // byte enables and lane-replicated store data for the head op
    always_comb begin
        w_be    = '1;
        w_wdata = w_h_data;
        case (w_h_size)
            2'd0: begin
                w_be    = {{(NB-1){1'b0}}, 1'b1} << w_off;
                w_wdata = {NB{w_h_data[7:0]}};
            end
            2'd1: begin
                w_be    = {{(NB-2){1'b0}}, 2'b11} << w_off;
                w_wdata = {(NB/2){w_h_data[15:0]}};
            end
            default: begin
                w_be    = '1;
                w_wdata = w_h_data;
            end
        endcase
    end

    // aligned words have a zero lane offset, so the shifted value doubles as the word result
    assign w_shift = bus.mem_rdata >> {w_off, 3'b000};

    // load lane extraction with sign/zero extension
    always_comb begin
        w_ld = w_shift;
        case (w_h_size)
            2'd0:    w_ld = {{(XLEN-8){!w_h_uns && w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_ld = {{(XLEN-16){!w_h_uns && w_shift[15]}}, w_shift[15:0]};
            default: w_ld = w_shift;
        endcase
    end

    // next-state and handshake outputs; IDLE issues the request directly so an aligned
    // head reaches memory in the first cycle it is visible
    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_pop       = 1'b0;
        w_cap       = 1'b0;
        w_cap_data  = '0;
        w_cap_exc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_h_mis) begin
                        w_cap       = 1'b1;
                        w_cap_exc   = 1'b1;
                        w_state_nxt = S_RESP;
                    end else if (!r_discard) begin
                        w_mem_req = 1'b1;
                        if (!bus.mem_gnt) begin
                            w_state_nxt = S_REQ;
                        end else if (w_h_store) begin
                            w_cap       = 1'b1;
                            w_state_nxt = S_RESP;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
            end
            S_REQ: begin
                w_mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    if (w_h_store) begin
                        w_cap       = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_cap       = 1'b1;
                    w_cap_data  = w_ld;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.cdb_ready) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // a load whose read data is still owed when flushed must have that rvalid swallowed
    assign w_disc_set = flush &&
                        (((r_state == S_WAIT) && !bus.mem_rvalid) ||
                         (w_mem_req && bus.mem_gnt && !w_h_store));

    // state, pointers and discard flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_discard <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_rptr <= r_wptr;
            end else begin
                if (w_enq) begin
                    r_wptr <= r_wptr + {{PW{1'b0}}, 1'b1};
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + {{PW{1'b0}}, 1'b1};
                end
            end
            if (w_disc_set) begin
                r_discard <= 1'b1;
            end else if (r_discard && bus.mem_rvalid) begin
                r_discard <= 1'b0;
            end
        end
    end

    // CDB payload is latched on entry to RESP and held until the broadcast is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_data <= '0;
            r_cdb_tag  <= '0;
            r_cdb_exc  <= 1'b0;
        end else if (w_cap) begin
            r_cdb_data <= w_cap_data;
            r_cdb_tag  <= w_h_tag;
            r_cdb_exc  <= w_cap_exc;
        end
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_req && w_h_store;
    assign bus.mem_be    = w_mem_req ? w_be : '0;
    assign bus.mem_addr  = w_mem_req ? {w_h_ea[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
    assign bus.mem_wdata = w_mem_req ? w_wdata : '0;

    assign bus.cdb_valid = (r_state == S_RESP);
    assign bus.cdb_data  = r_cdb_data;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_exc   = r_cdb_exc;
endmodule

// File: tb/tb_agu_lsq_unit.sv
// tb/tb_agu_lsq_unit.sv - scoreboard bench for agu_lsq_unit
module tb_agu_lsq_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  tag;
        logic        exc;
    } cdb_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic gnt_lvl = 1'b1;
    logic rdy_lvl = 1'b1;
    logic toggle  = 1'b0;
    logic tog     = 1'b0;
    int   rv_delay = 1;

    int checks = 0;
    int errors = 0;

    mem_exp_t    exp_mem[$];
    cdb_exp_t    exp_cdb[$];
    logic [31:0] rdata_q[$];

    always #5 clk = ~clk;

    agu_lsq_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    agu_lsq_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    assign bus.mem_gnt   = gnt_lvl;
    assign bus.cdb_ready = toggle ? tog : rdy_lvl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
        mem_exp_t e;
        e.addr = a; e.be = be; e.we = we; e.wdata = wd;
        exp_mem.push_back(e);
    endtask

    task automatic push_cdb(input logic [31:0] d, input logic [5:0] t, input logic x);
        cdb_exp_t e;
        e.data = d; e.tag = t; e.exc = x;
        exp_cdb.push_back(e);
    endtask

    // call at posedge+1; returns one cycle after the accepting cycle, at posedge+1
    task automatic issue(input logic [31:0] base, input logic [31:0] imm, input logic [31:0] data,
                         input logic st, input logic [1:0] sz, input logic uns, input logic [5:0] tag);
        int n;
        bus.issue_base = base; bus.issue_imm = imm; bus.issue_data = data;
        bus.issue_store = st; bus.issue_size = sz; bus.issue_unsigned = uns; bus.issue_tag = tag;
        bus.issue_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.issue_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("issue_accept", bus.issue_ready, 1'b1);
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_cdb.size() > 0 || exp_mem.size() > 0) && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk(name, exp_cdb.size() + exp_mem.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1 tog = ~tog;
    end

    // memory responder: returns queued read data rv_delay cycles after a load grant
    initial begin
        logic [31:0] d;
        int dl;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_req && bus.mem_gnt && !bus.mem_we) begin
                d  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
                dl = rv_delay;
                repeat (dl) @(posedge clk);
                #1;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = d;
                @(posedge clk);
                #1;
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
            end
        end
    end

    // memory-side monitor: compares each granted request, checks stability while stalled
    initial begin
        mem_exp_t e;
        logic held;
        logic [31:0] h_addr;
        held = 1'b0;
        h_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else if (bus.mem_req) begin
                if (held) chk("mem_addr_stable", bus.mem_addr, h_addr);
                if (bus.mem_gnt) begin
                    if (exp_mem.size() == 0) begin
                        chk("mem_req_expected", exp_mem.size(), 1);
                    end else begin
                        e = exp_mem.pop_front();
                        chk("mem_addr", bus.mem_addr, e.addr);
                        chk("mem_be", {28'h0, bus.mem_be}, {28'h0, e.be});
                        chk("mem_we", bus.mem_we, e.we);
                        if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    h_addr = bus.mem_addr;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // CDB monitor: compares each accepted broadcast, checks payload held under back-pressure
    initial begin
        cdb_exp_t e;
        logic held;
        logic [31:0] h_data;
        logic [5:0]  h_tag;
        logic        h_exc;
        held = 1'b0;
        h_data = '0; h_tag = '0; h_exc = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else if (bus.cdb_valid) begin
                if (held) begin
                    chk("cdb_data_stable", bus.cdb_data, h_data);
                    chk("cdb_tag_stable", {26'h0, bus.cdb_tag}, {26'h0, h_tag});
                end
                if (bus.cdb_ready) begin
                    if (exp_cdb.size() == 0) begin
                        chk("cdb_valid_expected", exp_cdb.size(), 1);
                    end else begin
                        e = exp_cdb.pop_front();
                        chk("cdb_data", bus.cdb_data, e.data);
                        chk("cdb_tag", {26'h0, bus.cdb_tag}, {26'h0, e.tag});
                        chk("cdb_exc", bus.cdb_exc, e.exc);
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    h_data = bus.cdb_data; h_tag = bus.cdb_tag; h_exc = bus.cdb_exc;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.issue_valid = 1'b0; bus.issue_base = '0; bus.issue_imm = '0; bus.issue_data = '0;
        bus.issue_store = 1'b0; bus.issue_size = '0; bus.issue_unsigned = 1'b0; bus.issue_tag = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_issue_ready", bus.issue_ready, 1'b1);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
        chk("rst_cdb_valid", bus.cdb_valid, 1'b0);
        chk("rst_cdb_data", bus.cdb_data, 32'h0);
        chk("rst_cdb_tag", {26'h0, bus.cdb_tag}, 32'h0);
        chk("rst_cdb_exc", bus.cdb_exc, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // load word with latency N+1 req, N+3 cdb
        push_mem(32'h104, 4'hF, 1'b0, 32'h0);
        push_cdb(32'hDEADBEEF, 6'd5, 1'b0);
        rdata_q.push_back(32'hDEADBEEF);
        issue(32'h100, 32'h4, 32'h0, 1'b0, 2'd2, 1'b0, 6'd5);
        @(negedge clk); chk("ld_req_at_n1", bus.mem_req, 1'b1);
        @(negedge clk); chk("ld_cdb_not_n2", bus.cdb_valid, 1'b0);
        @(negedge clk); chk("ld_cdb_at_n3", bus.cdb_valid, 1'b1);
        @(posedge clk); #1;
        drain("drain_t1");

        // byte loads at lane 3, signed then unsigned
        push_mem(32'h100, 4'h8, 1'b0, 32'h0);
        push_cdb(32'hFFFFFF80, 6'd6, 1'b0);
        rdata_q.push_back(32'h80123456);
        issue(32'h100, 32'h3, 32'h0, 1'b0, 2'd0, 1'b0, 6'd6);
        push_mem(32'h100, 4'h8, 1'b0, 32'h0);
        push_cdb(32'h00000080, 6'd7, 1'b0);
        rdata_q.push_back(32'h80123456);
        issue(32'h100, 32'h3, 32'h0, 1'b0, 2'd0, 1'b1, 6'd7);
        drain("drain_t2_bytes");

        // store half at 0x102: cdb at N+2
        push_mem(32'h100, 4'hC, 1'b1, 32'h12341234);
        push_cdb(32'h0, 6'd8, 1'b0);
        issue(32'h100, 32'h2, 32'hAAAA1234, 1'b1, 2'd1, 1'b0, 6'd8);
        @(negedge clk); chk("st_req_at_n1", bus.mem_req, 1'b1);
        @(negedge clk); chk("st_cdb_at_n2", bus.cdb_valid, 1'b1);
        @(posedge clk); #1;
        drain("drain_t2_store");

        // signed half at upper lane, size 3 as word, address wrap
        push_mem(32'h100, 4'hC, 1'b0, 32'h0);
        push_cdb(32'hFFFF8001, 6'd10, 1'b0);
        rdata_q.push_back(32'h80015555);
        issue(32'h100, 32'h2, 32'h0, 1'b0, 2'd1, 1'b0, 6'd10);
        push_mem(32'h200, 4'hF, 1'b0, 32'h0);
        push_cdb(32'h13572468, 6'd12, 1'b0);
        rdata_q.push_back(32'h13572468);
        issue(32'h200, 32'h0, 32'h0, 1'b0, 2'd3, 1'b0, 6'd12);
        push_mem(32'h4, 4'hF, 1'b0, 32'h0);
        push_cdb(32'h0BADF00D, 6'd13, 1'b0);
        rdata_q.push_back(32'h0BADF00D);
        issue(32'hFFFFFFFE, 32'h6, 32'h0, 1'b0, 2'd2, 1'b0, 6'd13);
        drain("drain_t2_misc");

        // misaligned word: no memory request, exception at N+2
        push_cdb(32'h0, 6'd9, 1'b1);
        issue(32'h100, 32'h2, 32'h0, 1'b0, 2'd2, 1'b0, 6'd9);
        @(negedge clk); chk("mis_no_req", bus.mem_req, 1'b0);
        @(negedge clk); chk("mis_cdb_at_n2", bus.cdb_valid, 1'b1);
        @(posedge clk); #1;
        push_cdb(32'h0, 6'd11, 1'b1);
        issue(32'h100, 32'h1, 32'h0, 1'b0, 2'd1, 1'b0, 6'd11);
        drain("drain_t3");

        // back-pressure: fill queue with grant withheld, then release with toggling cdb_ready
        gnt_lvl = 1'b0;
        push_mem(32'h300, 4'hF, 1'b1, 32'hA0A0A0A0); push_cdb(32'h0, 6'd20, 1'b0);
        push_mem(32'h304, 4'hF, 1'b0, 32'h0);        push_cdb(32'h11111111, 6'd21, 1'b0);
        push_mem(32'h308, 4'h2, 1'b1, 32'h5A5A5A5A); push_cdb(32'h0, 6'd22, 1'b0);
        push_mem(32'h30C, 4'hC, 1'b0, 32'h0);        push_cdb(32'h00009876, 6'd23, 1'b0);
        push_mem(32'h310, 4'hF, 1'b1, 32'h24242424); push_cdb(32'h0, 6'd24, 1'b0);
        rdata_q.push_back(32'h11111111);
        rdata_q.push_back(32'h98760000);
        issue(32'h300, 32'h0, 32'hA0A0A0A0, 1'b1, 2'd2, 1'b0, 6'd20);
        issue(32'h300, 32'h4, 32'h0, 1'b0, 2'd2, 1'b0, 6'd21);
        issue(32'h300, 32'h9, 32'h0000005A, 1'b1, 2'd0, 1'b0, 6'd22);
        issue(32'h300, 32'hE, 32'h0, 1'b0, 2'd1, 1'b1, 6'd23);
        @(negedge clk); chk("full_ready_low", bus.issue_ready, 1'b0);
        @(posedge clk); #1;
        bus.issue_base = 32'h310; bus.issue_imm = 32'h0; bus.issue_data = 32'h24242424;
        bus.issue_store = 1'b1; bus.issue_size = 2'd2; bus.issue_unsigned = 1'b0; bus.issue_tag = 6'd24;
        bus.issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_hold", bus.issue_ready, 1'b0);
            chk("stall_addr", bus.mem_addr, 32'h300);
        end
        @(posedge clk); #1;
        gnt_lvl = 1'b1;
        toggle  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.issue_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("fifth_accept", bus.issue_ready, 1'b1);
        @(posedge clk); #1 bus.issue_valid = 1'b0;
        drain("drain_t4");
        toggle = 1'b0;

        // flush while the first load waits for data; its late rvalid must be swallowed
        rv_delay = 4;
        push_mem(32'h400, 4'hF, 1'b0, 32'h0);
        rdata_q.push_back(32'h55555555);
        issue(32'h400, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 6'd30);
        issue(32'h404, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 6'd31);
        flush = 1'b1;
        rv_delay = 1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_cdb_quiet", bus.cdb_valid, 1'b0);
        chk("flush_req_quiet", bus.mem_req, 1'b0);
        @(posedge clk); #1;
        push_mem(32'h408, 4'hF, 1'b0, 32'h0);
        push_cdb(32'hCAFEF00D, 6'd32, 1'b0);
        rdata_q.push_back(32'hCAFEF00D);
        issue(32'h408, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 6'd32);
        @(negedge clk); chk("discard_blocks_req", bus.mem_req, 1'b0);
        @(posedge clk); #1;
        drain("drain_t5");

        // asynchronous reset between edges while a request is stalled
        gnt_lvl = 1'b0;
        issue(32'h500, 32'h0, 32'h77777777, 1'b1, 2'd2, 1'b0, 6'd40);
        @(posedge clk);
        #3;
        chk("pre_rst_req", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", bus.mem_req, 1'b0);
        chk("arst_cdb_valid", bus.cdb_valid, 1'b0);
        chk("arst_issue_ready", bus.issue_ready, 1'b1);
        chk("arst_mem_addr", bus.mem_addr, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        gnt_lvl = 1'b1;
        idle(3);
        @(negedge clk); chk("post_rst_idle", bus.mem_req, 1'b0);

        chk("final_mem_queue", exp_mem.size(), 0);
        chk("final_cdb_queue", exp_cdb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
